store_drain_buffer: RTL and testbench

//  Write-side partner of the core's data-memory read path. Committed stores (from the commit

---
 rtl/store_drain_buffer.sv | 112 +++++++++++
 tb/tb_store_drain_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_buffer.sv
// In-order store drain buffer: committed stores queue here, drain one per cycle to data memory,
// forward to younger loads, and a fence waits until every queued store has been written.
//
// state | meaning
// RUN   | stores accepted while not full; entries drain to memory
// FENCE | stores blocked; draining continues until empty, then fence_ack pulses

module store_drain_buffer #(
  parameter int DEPTH     = 4,
  parameter int DEPTH_LOG = 2,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st_valid,
  output logic                 st_ready,
  input  logic [ADDR_W-1:0]    st_addr,
  input  logic [DATA_W-1:0]    st_data,
  output logic                 mem_wvalid,
  input  logic                 mem_wready,
  output logic [ADDR_W-1:0]    mem_waddr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [ADDR_W-1:0]    ld_addr,
  output logic                 ld_hit,
  output logic [DATA_W-1:0]    ld_data,
  input  logic                 fence_req,
  output logic                 fence_ack,
  output logic [DEPTH_LOG:0]   count
);

  localparam int PTR_W = DEPTH_LOG + 1;

  typedef enum logic {RUN, FENCE} state_t;

  state_t                state_q;
  logic                  fence_ack_q;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [PTR_W-1:0]      count_d;
  logic [ADDR_W-1:0]     addr_q [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];
  logic                  empty, full, enq, deq;
  logic [DEPTH_LOG-1:0]  slot;

  assign empty      = (head_q == tail_q);
  assign full       = (head_q[DEPTH_LOG-1:0] == tail_q[DEPTH_LOG-1:0]) &&
                      (head_q[DEPTH_LOG] != tail_q[DEPTH_LOG]);
  assign count      = tail_q - head_q;
  assign st_ready   = !full && (state_q == RUN);
  assign enq        = st_valid && st_ready;
  assign mem_wvalid = !empty;
  assign deq        = mem_wvalid && mem_wready;
  assign mem_waddr  = addr_q[head_q[DEPTH_LOG-1:0]];
  assign mem_wdata  = data_q[head_q[DEPTH_LOG-1:0]];
  assign fence_ack  = fence_ack_q;

  assign head_d  = head_q + PTR_W'(deq);
  assign tail_d  = tail_q + PTR_W'(enq);
  assign count_d = tail_d - head_d;

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    slot    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_q[DEPTH_LOG-1:0] + DEPTH_LOG'(i);
      if ((PTR_W'(i) < count) && (addr_q[slot] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = data_q[slot];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q[DEPTH_LOG-1:0]] <= st_addr;
      data_q[tail_q[DEPTH_LOG-1:0]] <= st_data;
    end
  end

  // fence_ack reflects count reaching zero at this edge, i.e. one cycle after the last write.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      state_q     <= RUN;
      fence_ack_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      fence_ack_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (fence_req) begin
            if (count_d == '0) fence_ack_q <= 1'b1;
            else               state_q     <= FENCE;
          end
        end
        FENCE: begin
          if (count_d == '0) begin
            fence_ack_q <= 1'b1;
            state_q     <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer: ordering, backpressure, forwarding, wrap, fence, reset.

module tb_store_drain_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       st_valid;
  logic       st_ready;
  logic [3:0] st_addr;
  logic [7:0] st_data;
  logic       mem_wvalid;
  logic       mem_wready;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [3:0] ld_addr;
  logic       ld_hit;
  logic [7:0] ld_data;
  logic       fence_req;
  logic       fence_ack;
  logic [2:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  store_drain_buffer dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .fence_req(fence_req), .fence_ack(fence_ack), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] d);
    st_valid = 1'b1; st_addr = a; st_data = d;
    step();
    st_valid = 1'b0;
  endtask

  logic [3:0]  ta [10] = '{4'h1, 4'h7, 4'hF, 4'h0, 4'h7, 4'h3, 4'hC, 4'h9, 4'h2, 4'h5};
  logic [7:0]  td [10] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87, 8'h98, 8'hA9};
  logic [11:0] q [$];
  logic [11:0] exp_wr;

  initial begin
    int sent, written, ack_cnt, ack_cyc, third_cyc, wr_cnt;

    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    mem_wready = 1'b0; ld_addr = '0; fence_req = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wvalid", 32'(mem_wvalid), 32'd0);
    chk("rst_ldhit", 32'(ld_hit), 32'd0);
    chk("rst_stready", 32'(st_ready), 32'd1);
    chk("rst_ack", 32'(fence_ack), 32'd0);

    // 1: single store, one-cycle latency then drained
    mem_wready = 1'b1;
    push(4'd3, 8'h11);
    #1;
    chk("t1_wvalid", 32'(mem_wvalid), 32'd1);
    chk("t1_waddr", 32'(mem_waddr), 32'd3);
    chk("t1_wdata", 32'(mem_wdata), 32'h11);
    step();
    chk("t1_empty", 32'(mem_wvalid), 32'd0);
    chk("t1_count", 32'(count), 32'd0);

    // 2: fill with writes stalled, fifth store refused, drain in order
    mem_wready = 1'b0;
    for (int i = 0; i < 4; i++) push(4'(i), 8'(8'h20 + i));
    #1;
    chk("t2_count", 32'(count), 32'd4);
    chk("t2_stready", 32'(st_ready), 32'd0);
    push(4'd9, 8'h99);
    chk("t2_count5", 32'(count), 32'd4);
    chk("t2_hold_addr", 32'(mem_waddr), 32'd0);
    st_valid = 1'b1; st_addr = 4'd9; st_data = 8'h99; mem_wready = 1'b1;
    #1;
    chk("t2_full_deq_ready", 32'(st_ready), 32'd0);
    step();
    st_valid = 1'b0;
    chk("t2_wr0_done_count", 32'(count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      chk("t2_wvalid", 32'(mem_wvalid), 32'd1);
      chk("t2_waddr", 32'(mem_waddr), 32'(i));
      chk("t2_wdata", 32'(mem_wdata), 32'(8'h20 + i));
      step();
    end
    chk("t2_empty", 32'(mem_wvalid), 32'd0);

    // 3: forwarding picks the youngest match
    mem_wready = 1'b0;
    push(4'd5, 8'hAA);
    push(4'd5, 8'hBB);
    ld_addr = 4'd5; #1;
    chk("t3_hit", 32'(ld_hit), 32'd1);
    chk("t3_data", 32'(ld_data), 32'hBB);
    ld_addr = 4'd6; #1;
    chk("t3_miss", 32'(ld_hit), 32'd0);
    chk("t3_miss_data", 32'(ld_data), 32'd0);
    ld_addr = 4'd5; mem_wready = 1'b1; #1;
    chk("t3_wr_aa", 32'(mem_wdata), 32'hAA);
    chk("t3_hit_deq", 32'(ld_data), 32'hBB);
    step();
    chk("t3_wr_bb", 32'(mem_wdata), 32'hBB);
    step();
    chk("t3_gone", 32'(ld_hit), 32'd0);

    // 4: ten stores across the wrap with random backpressure
    sent = 0; written = 0;
    for (int cyc = 0; cyc < 200 && written < 10; cyc++) begin
      st_valid   = (sent < 10);
      st_addr    = (sent < 10) ? ta[sent] : 4'd0;
      st_data    = (sent < 10) ? td[sent] : 8'd0;
      mem_wready = 1'($urandom_range(0, 1));
      #1;
      chk("t4_count", 32'(count), 32'(q.size()));
      chk("t4_count_max", 32'(count <= 3'd4), 32'd1);
      if (mem_wvalid && mem_wready) begin
        if (q.size() == 0) chk("t4_spurious_wr", 32'd1, 32'd0);
        else begin
          exp_wr = q.pop_front();
          chk("t4_wr", 32'({mem_waddr, mem_wdata}), 32'(exp_wr));
          written++;
        end
      end
      if (st_valid && st_ready) begin
        q.push_back({st_addr, st_data});
        sent++;
      end
      step();
    end
    st_valid = 1'b0;
    chk("t4_all_written", 32'(written), 32'd10);

    // 5: fence with three queued stores
    mem_wready = 1'b0;
    push(4'd1, 8'h01); push(4'd2, 8'h02); push(4'd3, 8'h03);
    fence_req = 1'b1;
    step();
    fence_req = 1'b0;
    chk("t5_stready_blk", 32'(st_ready), 32'd0);
    push(4'd4, 8'h04);
    chk("t5_no_enq", 32'(count), 32'd3);
    mem_wready = 1'b1;
    ack_cnt = 0; ack_cyc = -1; third_cyc = -1; wr_cnt = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      if (fence_ack) begin
        ack_cnt++; ack_cyc = cyc;
        chk("t5_stready_at_ack", 32'(st_ready), 32'd1);
      end
      if (mem_wvalid && mem_wready) begin
        wr_cnt++;
        if (wr_cnt == 3) third_cyc = cyc;
      end
      step();
    end
    chk("t5_ack_count", 32'(ack_cnt), 32'd1);
    chk("t5_ack_timing", 32'(ack_cyc), 32'(third_cyc + 1));
    chk("t5_writes", 32'(wr_cnt), 32'd3);

    // fence on an empty buffer acks next cycle
    fence_req = 1'b1;
    step();
    fence_req = 1'b0;
    chk("t5_empty_ack", 32'(fence_ack), 32'd1);
    step();
    chk("t5_empty_ack_drop", 32'(fence_ack), 32'd0);

    // 6: reset discards queued entries
    mem_wready = 1'b0;
    push(4'd8, 8'h81); push(4'd9, 8'h92); push(4'd8, 8'hA3);
    ld_addr = 4'd8;
    rst = 1'b1; mem_wready = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_wvalid", 32'(mem_wvalid), 32'd0);
    chk("t6_ldhit", 32'(ld_hit), 32'd0);
    chk("t6_ack", 32'(fence_ack), 32'd0);
    step();
    chk("t6_no_wr", 32'(mem_wvalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
